mbus_wait_bridge: RTL and testbench
===================================

// Module: mbus_wait_bridge
//
// PURPOSE
// Sits between the CPU memory bus (mbus_aout/mbus_dout/mbus_wen/mbus_din) and a
// slow req/ack memory or I/O slave. Converts each single-cycle CPU bus phase
// into a registered req/ack transaction and raises stall to the scheduler.
// The scheduler holds its current phase until the access completes.
// A timeout guards against a dead slave.
//
// PARAMETERS
// WIDTH      32   data bus width
// ADDR_SIZE  32   address bus width
// TIMEOUT    255  max REQ cycles without ack before abort (1..2**TOUT_W-1)
// TOUT_W     8    timeout counter width
//
// PORTS
// clk        in   1          system clock, all state on rising edge
// reset      in   1          asynchronous, active-low; 0 forces reset state
// cpu_req    in   1          CPU bus phase active (fetch or LD/ST mem phase)
// cpu_addr   in   ADDR_SIZE  CPU address (mbus_aout)
// cpu_wdata  in   WIDTH      CPU write data (mbus_dout)
// cpu_wen    in   1          CPU write enable (mbus_wen)
// cpu_rdata  out  WIDTH      read data to CPU (mbus_din)
// stall      out  1          hold scheduler phase while 1
// mem_req    out  1          request to slave, registered
// mem_addr   out  ADDR_SIZE  latched address, stable while mem_req=1
// mem_wdata  out  WIDTH      latched write data, stable while mem_req=1
// mem_wen    out  1          latched write flag, stable while mem_req=1
// mem_ack    in   1          slave completion, one or more cycles
// mem_rdata  in   WIDTH      slave read data, valid when mem_ack=1
// bus_err    out  1          sticky timeout flag
// err_clr    in   1          synchronous clear of bus_err
//
// BEHAVIOUR
// Reset (reset=0): state IDLE; mem_req=0; mem_addr, mem_wdata, cpu_rdata = 0;
//   mem_wen=0; bus_err=0; timeout count=0. Immediate, no clock needed.
// FSM states: IDLE, REQ, DONE.
// IDLE: if cpu_req=1, latch cpu_addr/cpu_wdata/cpu_wen into mem_*; clear count.
//   Go to REQ. Else stay.
// REQ: mem_req=1. On mem_ack=1: if mem_wen=0, cpu_rdata<=mem_rdata.
//   Drop mem_req and go to DONE. Else count++.
//   If count reaches TIMEOUT with no ack: cpu_rdata<={WIDTH{1'b1}} for a read.
//   Set bus_err=1, drop mem_req, go to DONE. Write timeouts leave cpu_rdata.
// DONE: one cycle, stall=0, always go to IDLE. A new access is started only
//   from IDLE. The CPU advances its phase on the DONE edge.
// stall = (state==IDLE & cpu_req) | (state==REQ). Combinational, so the first
//   cycle of a request is already stalled.
// Latency: ack in the first REQ cycle gives 3 cycles per access, with 2 stalled.
//   Each extra wait cycle of the slave adds 1.
// cpu_rdata holds its last value outside updates and after writes.
// mem_ack outside REQ is ignored. cpu_req dropping mid-REQ does not abort;
//   the transaction completes.
// Ack in the same cycle count hits TIMEOUT: ack wins, no error.
// err_clr=1 clears bus_err, except when a timeout sets it in the same cycle:
//   then set wins.
// Reset mid-REQ: mem_req drops asynchronously. The transaction is lost and the
//   slave must tolerate request withdrawal.
//
// TESTING
// 1. Zero-wait read: cpu_req=1, cpu_addr=0x100, slave acks the 1st REQ cycle
//    with 0xDEADBEEF -> stall=1 for 2 cycles, DONE cpu_rdata=0xDEADBEEF,
//    mem_req high for exactly 1 cycle.
// 2. Write, 3 waits: addr=0x20, wdata=0x12345678, wen=1, ack after 3 cycles
//    -> mem_* stable 4 cycles, stall=1 for 5 cycles, cpu_rdata unchanged.
// 3. Timeout, TIMEOUT=4, no ack on read -> mem_req high 4 cycles,
//    cpu_rdata=0xFFFFFFFF, bus_err=1 until err_clr pulse, then 0.
// 4. Back-to-back: cpu_req held high over two accesses (0x0, then 0x4) ->
//    one IDLE cycle between DONE and the next REQ, two distinct mem_req pulses.
// 5. Async reset asserted mid-REQ, between clock edges -> mem_req, stall,
//    bus_err = 0 at once. After reset release with cpu_req=0, the FSM stays IDLE.
// 6. Stray mem_ack pulses in IDLE and DONE -> no state change,
//    cpu_rdata unchanged.

Source files
------------

// File: rtl/mbus_wait_bridge.sv
// Bridges single-cycle CPU bus phases onto a registered req/ack slave interface.
// The scheduler is stalled until the slave acks or the timeout aborts the access.
module mbus_wait_bridge #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 32,
    parameter int TIMEOUT   = 255,
    parameter int TOUT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WIDTH-1:0]     cpu_wdata,
    input  logic                 cpu_wen,
    output logic [WIDTH-1:0]     cpu_rdata,
    output logic                 stall,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_wen,
    input  logic                 mem_ack,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 bus_err,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Count runs 0..TIMEOUT-1 over the REQ cycles, so the abort lands on REQ cycle TIMEOUT.
    localparam logic [TOUT_W-1:0] LAST = TOUT_W'(TIMEOUT - 1);

    state_t            state;
    logic [TOUT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            cpu_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            // A timeout below overrides this clear in the same cycle.
            if (err_clr)
                bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_wen   <= cpu_wen;
                        mem_req   <= 1'b1;
                        count     <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_wen)
                            cpu_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (count == LAST) begin
                        if (!mem_wen)
                            cpu_rdata <= '1;
                        bus_err <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational so the very first cycle of a request already holds the scheduler.
    assign stall = ((state == IDLE) && cpu_req) || (state == REQ);

endmodule

// File: tb/tb_mbus_wait_bridge.sv
// Directed bench for mbus_wait_bridge with TIMEOUT=4; expected values are hand-derived.
module tb_mbus_wait_bridge;

    logic        clk = 1'b0, reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_wen = 1'b0, mem_ack = 1'b0, err_clr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        stall, mem_req, mem_wen, bus_err;

    int n_chk = 0, n_pass = 0;
    int ns, nr;
    logic fm, st;

    mbus_wait_bridge #(.WIDTH(32), .ADDR_SIZE(32), .TIMEOUT(4), .TOUT_W(8)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next();
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    // Starts from IDLE just after an edge; returns at the negedge of the DONE cycle.
    task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input int waits, input logic do_ack, input logic [31:0] rd,
                              input logic stray, output int nstall, output int nreq,
                              output logic first_mr, output logic stable);
        int   reqcyc;
        logic done;
        reqcyc = 0; done = 1'b0; nstall = 0; nreq = 0; stable = 1'b1; first_mr = 1'b0;
        cpu_req = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_wen = w;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ack   = (do_ack && mem_req && reqcyc == waits) || (stray && !mem_req && reqcyc > 0);
            mem_rdata = mem_req ? rd : 32'h5A5A5A5A;
            @(negedge clk);
            if (c == 0) first_mr = mem_req;
            if (stall) nstall++;
            if (mem_req) begin
                nreq++; reqcyc++;
                if (mem_addr !== a || mem_wdata !== d || mem_wen !== w) stable = 1'b0;
            end
            if (!stall) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) chk("done_bound", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #3;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        next();

        // zero-wait read
        run_access(32'h100, 32'h0, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0, ns, nr, fm, st);
        chk("rd0_stall_cyc", 32'(ns), 32'd2);
        chk("rd0_req_cyc", 32'(nr), 32'd1);
        chk("rd0_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd0_stable", 32'(st), 32'd1);
        chk("rd0_first_idle", 32'(fm), 32'd0);
        next(); cpu_req = 1'b0;

        // write with 3 wait cycles
        run_access(32'h20, 32'h12345678, 1'b1, 3, 1'b1, 32'hCCCCCCCC, 1'b0, ns, nr, fm, st);
        chk("wr3_stall_cyc", 32'(ns), 32'd5);
        chk("wr3_req_cyc", 32'(nr), 32'd4);
        chk("wr3_stable", 32'(st), 32'd1);
        chk("wr3_rdata_kept", cpu_rdata, 32'hDEADBEEF);
        next(); cpu_req = 1'b0;
        next();

        // back-to-back with cpu_req held high
        run_access(32'h0, 32'hAAAA0000, 1'b0, 0, 1'b1, 32'h11111111, 1'b0, ns, nr, fm, st);
        chk("b2b0_req_cyc", 32'(nr), 32'd1);
        chk("b2b0_rdata", cpu_rdata, 32'h11111111);
        next();
        run_access(32'h4, 32'hAAAA0004, 1'b0, 0, 1'b1, 32'h22222222, 1'b0, ns, nr, fm, st);
        chk("b2b1_idle_gap", 32'(fm), 32'd0);
        chk("b2b1_req_cyc", 32'(nr), 32'd1);
        chk("b2b1_stable", 32'(st), 32'd1);
        chk("b2b1_rdata", cpu_rdata, 32'h22222222);
        next(); cpu_req = 1'b0;

        // stray acks while IDLE
        mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        chk("stray_idle_stall", 32'(stall), 32'd0);
        next(); mem_ack = 1'b1;
        @(negedge clk);
        chk("stray_idle_req", 32'(mem_req), 32'd0);
        chk("stray_idle_rdata", cpu_rdata, 32'h22222222);
        next();

        // ack on the last allowed REQ cycle wins over timeout; stray ack in DONE
        run_access(32'h40, 32'h0, 1'b0, 3, 1'b1, 32'h0BADCAFE, 1'b1, ns, nr, fm, st);
        chk("ackto_req_cyc", 32'(nr), 32'd4);
        chk("ackto_stall_cyc", 32'(ns), 32'd5);
        chk("ackto_rdata", cpu_rdata, 32'h0BADCAFE);
        chk("ackto_no_err", 32'(bus_err), 32'd0);
        next(); cpu_req = 1'b0;
        @(negedge clk);
        chk("stray_done_rdata", cpu_rdata, 32'h0BADCAFE);
        chk("stray_done_req", 32'(mem_req), 32'd0);
        next();

        // write timeout keeps cpu_rdata, sets bus_err; err_clr pulse clears it
        run_access(32'h84, 32'h99, 1'b1, 0, 1'b0, 32'h0, 1'b0, ns, nr, fm, st);
        chk("wto_req_cyc", 32'(nr), 32'd4);
        chk("wto_rdata_kept", cpu_rdata, 32'h0BADCAFE);
        chk("wto_err", 32'(bus_err), 32'd1);
        next(); cpu_req = 1'b0; err_clr = 1'b1;
        next(); err_clr = 1'b0;
        @(negedge clk);
        chk("errclr_cleared", 32'(bus_err), 32'd0);
        next();

        // read timeout
        run_access(32'h80, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0, ns, nr, fm, st);
        chk("rto_req_cyc", 32'(nr), 32'd4);
        chk("rto_stall_cyc", 32'(ns), 32'd5);
        chk("rto_rdata", cpu_rdata, 32'hFFFFFFFF);
        chk("rto_err", 32'(bus_err), 32'd1);
        next(); cpu_req = 1'b0;
        next();
        @(negedge clk);
        chk("rto_err_sticky", 32'(bus_err), 32'd1);

        // async reset between edges in the middle of REQ
        next(); cpu_req = 1'b1; cpu_addr = 32'h300; cpu_wen = 1'b0;
        next();
        @(negedge clk);
        chk("arst_in_req", 32'(mem_req), 32'd1);
        #2; reset = 1'b0; cpu_req = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_bus_err", 32'(bus_err), 32'd0);
        chk("arst_rdata", cpu_rdata, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1; reset = 1'b1;
        next(); next(); next();
        @(negedge clk);
        chk("post_rst_req", 32'(mem_req), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        next();

        // timeout and err_clr in the same cycle: set wins
        err_clr = 1'b1;
        run_access(32'h90, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0, ns, nr, fm, st);
        chk("setwins_err", 32'(bus_err), 32'd1);
        next(); cpu_req = 1'b0;
        @(negedge clk);
        chk("setwins_then_clr", 32'(bus_err), 32'd0);
        err_clr = 1'b0;
        next();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
